taint_monitor: RTL and testbench
================================

Name: taint_monitor

Overview:
Downstream consumer of the combinational operand taint tagger. Takes the tagged 64-bit operand-pair dword (two 32-bit lanes, bit 63 and bit 31 = lane taint tags) through a valid/ready handshake and registers it onward to the ALU. Counts tainted ALU operand pairs, raises a sticky alarm at a threshold, and logs tainted dwords in a small first-word-fall-through (FWFT) FIFO for host readout. Non-ALU instructions pass through unchecked.

Parameters:
LOG_AW, 4, log2 of log FIFO depth (depth 16)
CNT_W, 16, taint counter width
THRESH, 8, tainted-count value at which alarm asserts (1..2^CNT_W-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream dword valid
in_ready  out  1  monitor can accept
in_data  in  64  tagged operand pair; [63]=hi-lane tag, [31]=lo-lane tag
in_alu  in  1  qualifier: dword belongs to an ALU instruction
out_valid  out  1  registered dword valid to ALU
out_ready  in  1  ALU accepts
out_data  out  64  registered copy of in_data, unmodified
out_taint  out  1  registered taint flag for out_data
clr  in  1  clears counter, alarm and overflow flag
taint_cnt  out  CNT_W  saturating count of tainted accepts
alarm  out  1  sticky, taint_cnt >= THRESH
log_rd_en  in  1  pop log head
log_rd_data  out  64  log head (FWFT)
log_empty  out  1  log FIFO empty
log_count  out  LOG_AW+1  entries held
log_ovf  out  1  sticky: tainted dword dropped, log full

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_taint=0, taint_cnt=0, alarm=0, log_ovf=0, log_count=0, log_empty=1, log_rd_data=0. FIFO pointers=0.
- Output stage: single register; in_ready = !out_valid | out_ready (combinational, no bubble). Accept = in_valid & in_ready. On accept: out_data<=in_data, out_taint<=tainted, out_valid<=1. If out_valid & out_ready & !accept: out_valid<=0. Latency 1 cycle. out_data and out_taint stay stable while out_valid & !out_ready.
- tainted = in_alu & (in_data[63] | in_data[31]). Non-ALU dwords: tainted=0, never counted or logged.
- Counter: increments by 1 on a tainted accept; saturates at 2^CNT_W-1, no wrap.
- alarm: set on the cycle the registered count reaches >= THRESH (alarm rises same edge taint_cnt becomes THRESH); sticky.
- clr: on that edge taint_cnt, alarm and log_ovf go to 0; FIFO contents untouched. A tainted accept in the same cycle as clr yields taint_cnt=1 (and alarm=1 only if THRESH==1).
- Log FIFO: depth 2^LOG_AW; push on tainted accept. Pop on log_rd_en & !log_empty; log_rd_en when empty is ignored. Push when full with no pop: data dropped, log_ovf<=1. Push and pop in the same cycle when full: both performed, no drop. Push and pop in the same cycle when empty: push only. Pointers wrap modulo depth. log_rd_data = mem[rd_ptr], and is 0 when empty.
- Logging and counting are independent of out_ready; logging happens at accept time, not at ALU consumption.
- Reset mid-transfer: in-flight output dword is lost, and log and counters clear.

Decomposition:
- Package taint_pkg: DWORD_W=64, LANE_W=32, TAG_HI=63, TAG_LO=31, and a function is_tainted(dword). The upstream tagger shares the same package.
- One sub-module: taint_log_fifo (synchronous FWFT FIFO with full/empty/count and drop-on-full). The top level holds the handshake register, counter and alarm.

Test Plan:
- Reset, then stream 0x00000001_00000002 with in_alu=1 and out_ready=1 -> out_data identical one cycle later, out_taint=0, taint_cnt=0, log_empty=1.
- Send 0x80000000_00000005 (alu=1), then 0x00000003_80000000 (alu=0) -> taint_cnt=1, log_count=1, log_rd_data=0x80000000_00000005; second dword passes through with out_taint=0.
- THRESH=8: eight tainted accepts -> alarm rises exactly on the edge taint_cnt becomes 8; pulse clr together with a ninth tainted accept -> taint_cnt=1, alarm=0.
- Hold out_ready=0 with out_valid=1 -> in_ready=0 and out_data stable; release out_ready -> the next dword is accepted in the same cycle, with no bubble.
- Seventeen tainted accepts with no reads -> log_count=16, log_ovf=1, and the 17th is dropped; the same scenario with a pop in the full cycle -> no drop and log_ovf=0.
- Assert rst_n low mid-stream with log_count=5 and alarm=1 -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/taint_pkg.sv
// Shared definitions for the operand taint tagger and its downstream monitor.
package taint_pkg;

    localparam int unsigned DWORD_W = 64;
    localparam int unsigned LANE_W  = 32;
    localparam int unsigned TAG_HI  = 63;
    localparam int unsigned TAG_LO  = 31;

    // A dword carries taint if either lane tag is set.
    function automatic logic is_tainted(input logic [DWORD_W-1:0] dword);
        return dword[TAG_HI] | dword[TAG_LO];
    endfunction

endpackage

// File: rtl/taint_log_fifo.sv
// First-word-fall-through log FIFO; a push into a full FIFO is dropped and flagged
// unless a pop frees the slot in the same cycle.
module taint_log_fifo
    import taint_pkg::*;
#(
    parameter int unsigned LOG_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [DWORD_W-1:0] wdata_i,
    output logic [DWORD_W-1:0] rdata_o,
    output logic               empty_o,
    output logic [LOG_AW:0]    count_o,
    output logic               drop_o
);

    localparam int unsigned Depth = 1 << LOG_AW;
    localparam logic [LOG_AW-1:0] PtrOne = LOG_AW'(1);
    localparam logic [LOG_AW:0]   CntOne = (LOG_AW + 1)'(1);
    localparam logic [LOG_AW:0]   CntFull = (LOG_AW + 1)'(Depth);

    logic [DWORD_W-1:0] mem_q [Depth];
    logic [LOG_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG_AW:0]    count_q, count_d;
    logic               empty, full, pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntFull);
    // A pop on an empty FIFO is ignored, so a push/pop pair when empty is push-only.
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);
    assign drop_o  = push_i & full & ~pop_ok;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while not covered by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/taint_monitor.sv
// Registers tagged operand pairs onward to the ALU, counts tainted ALU operand pairs,
// raises a sticky alarm at a threshold and logs tainted dwords for host readout.
module taint_monitor
    import taint_pkg::*;
#(
    parameter int unsigned LOG_AW = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWORD_W-1:0] in_data,
    input  logic               in_alu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWORD_W-1:0] out_data,
    output logic               out_taint,
    input  logic               clr,
    output logic [CNT_W-1:0]   taint_cnt,
    output logic               alarm,
    input  logic               log_rd_en,
    output logic [DWORD_W-1:0] log_rd_data,
    output logic               log_empty,
    output logic [LOG_AW:0]    log_count,
    output logic               log_ovf
);

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

    logic               out_valid_q, out_valid_d;
    logic [DWORD_W-1:0] out_data_q, out_data_d;
    logic               out_taint_q, out_taint_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               alarm_q, alarm_d;
    logic               ovf_q, ovf_d;
    logic               accept, tainted, taint_acc, log_drop;

    // No-bubble skid-free stage: a slot frees up in the same cycle the ALU consumes.
    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign tainted   = in_alu & is_tainted(in_data);
    assign taint_acc = accept & tainted;

    // Output stage next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_taint_d = out_taint_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_taint_d = tainted;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Counter, alarm and overflow next-state; clr clears first, then the current event applies.
    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (taint_acc && (cnt_base != CntMax)) begin
            cnt_d = cnt_base + CntOne;
        end
        alarm_d = clr ? 1'b0 : alarm_q;
        if (cnt_d >= ThreshVal) begin
            alarm_d = 1'b1;
        end
        ovf_d = (clr ? 1'b0 : ovf_q) | log_drop;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_taint_q <= 1'b0;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_taint_q <= out_taint_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            ovf_q       <= ovf_d;
        end
    end

    taint_log_fifo #(
        .LOG_AW (LOG_AW)
    ) u_log (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (taint_acc),
        .pop_i   (log_rd_en),
        .wdata_i (in_data),
        .rdata_o (log_rd_data),
        .empty_o (log_empty),
        .count_o (log_count),
        .drop_o  (log_drop)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_taint = out_taint_q;
    assign taint_cnt = cnt_q;
    assign alarm     = alarm_q;
    assign log_ovf   = ovf_q;

endmodule

// File: tb/tb_taint_monitor.sv
// Directed bench for taint_monitor with default parameters (depth 16, THRESH 8).
module tb_taint_monitor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_alu;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_taint;
    logic        clr;
    logic [15:0] taint_cnt;
    logic        alarm;
    logic        log_rd_en;
    logic [63:0] log_rd_data;
    logic        log_empty;
    logic [4:0]  log_count;
    logic        log_ovf;

    int checks = 0;
    int errors = 0;

    taint_monitor #(
        .LOG_AW (4),
        .CNT_W  (16),
        .THRESH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_alu      (in_alu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_taint   (out_taint),
        .clr         (clr),
        .taint_cnt   (taint_cnt),
        .alarm       (alarm),
        .log_rd_en   (log_rd_en),
        .log_rd_data (log_rd_data),
        .log_empty   (log_empty),
        .log_count   (log_count),
        .log_ovf     (log_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accept attempt: present a dword for one edge, then sample 1 time unit later.
    task automatic send(input logic [63:0] d, input logic alu);
        in_valid = 1'b1;
        in_data  = d;
        in_alu   = alu;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        log_rd_en = 1'b1;
        @(posedge clk);
        #1;
        log_rd_en = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
        check({tag, "_odata"}, out_data, 64'd0);
        check({tag, "_otaint"}, 64'(out_taint), 64'd0);
        check({tag, "_cnt"}, 64'(taint_cnt), 64'd0);
        check({tag, "_alarm"}, 64'(alarm), 64'd0);
        check({tag, "_ovf"}, 64'(log_ovf), 64'd0);
        check({tag, "_lcount"}, 64'(log_count), 64'd0);
        check({tag, "_lempty"}, 64'(log_empty), 64'd1);
        check({tag, "_lrdata"}, log_rd_data, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_alu    = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        log_rd_en = 1'b0;
        #2;
        check_reset_vals("rst");
        check("rst_inready", 64'(in_ready), 64'd1);
        #21;
        rst_n = 1'b1;
        idle();

        // Clean ALU dword passes through one cycle later, untainted.
        send(64'h00000001_00000002, 1'b1);
        check("pass_valid", 64'(out_valid), 64'd1);
        check("pass_data", out_data, 64'h00000001_00000002);
        check("pass_taint", 64'(out_taint), 64'd0);
        check("pass_cnt", 64'(taint_cnt), 64'd0);
        check("pass_lempty", 64'(log_empty), 64'd1);

        // Tainted ALU dword is counted and logged; tagged non-ALU dword is not.
        send(64'h80000000_00000005, 1'b1);
        check("t1_taint", 64'(out_taint), 64'd1);
        check("t1_cnt", 64'(taint_cnt), 64'd1);
        check("t1_lcount", 64'(log_count), 64'd1);
        check("t1_lrdata", log_rd_data, 64'h80000000_00000005);
        send(64'h00000003_80000000, 1'b0);
        check("nalu_data", out_data, 64'h00000003_80000000);
        check("nalu_taint", 64'(out_taint), 64'd0);
        check("nalu_cnt", 64'(taint_cnt), 64'd1);
        check("nalu_lcount", 64'(log_count), 64'd1);

        // Clear the count, then climb to the threshold with alternating lane tags.
        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("clr_cnt", 64'(taint_cnt), 64'd0);
        check("clr_lcount", 64'(log_count), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(64'h80000000_00000000 | 64'(i), 1'b1);
            else            send(64'h00000000_80000000 | 64'(i), 1'b1);
            check("thr_cnt", 64'(taint_cnt), 64'(i + 1));
            check("thr_alarm", 64'(alarm), (i >= 7) ? 64'd1 : 64'd0);
        end
        clr = 1'b1;
        send(64'h80000000_00000009, 1'b1);
        clr = 1'b0;
        check("clracc_cnt", 64'(taint_cnt), 64'd1);
        check("clracc_alarm", 64'(alarm), 64'd0);
        check("clracc_lcount", 64'(log_count), 64'd10);

        // Backpressure: output holds while stalled, then no-bubble handoff.
        idle();
        check("bp_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        send(64'h11111111_22222222, 1'b0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_inready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'h33333333_44444444;
        in_alu   = 1'b0;
        idle();
        check("bp_hold1", out_data, 64'h11111111_22222222);
        idle();
        check("bp_hold2", out_data, 64'h11111111_22222222);
        check("bp_inready2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release", 64'(in_ready), 64'd1);
        idle();
        in_valid = 1'b0;
        check("bp_next", out_data, 64'h33333333_44444444);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        idle();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Drain the log in order.
        check("log_head0", log_rd_data, 64'h80000000_00000005);
        pop();
        check("log_head1", log_rd_data, 64'h80000000_00000000);
        for (int i = 0; i < 9; i++) pop();
        check("drain_empty", 64'(log_empty), 64'd1);
        check("drain_rdata", log_rd_data, 64'd0);
        pop();
        check("empty_pop_count", 64'(log_count), 64'd0);

        // Push and pop together while empty: push only.
        log_rd_en = 1'b1;
        send(64'h00000000_800000AA, 1'b1);
        log_rd_en = 1'b0;
        check("ep_count", 64'(log_count), 64'd1);
        check("ep_head", log_rd_data, 64'h00000000_800000AA);
        pop();

        // Seventeen tainted accepts without reads: last one dropped.
        for (int i = 0; i < 17; i++) begin
            send(64'h80000000_00001000 + 64'(i), 1'b1);
            if (i == 15) begin
                check("full_count", 64'(log_count), 64'd16);
                check("full_ovf", 64'(log_ovf), 64'd0);
            end
        end
        check("drop_count", 64'(log_count), 64'd16);
        check("drop_ovf", 64'(log_ovf), 64'd1);
        check("drop_head", log_rd_data, 64'h80000000_00001000);
        check("drop_cnt", 64'(taint_cnt), 64'd19);
        check("drop_alarm", 64'(alarm), 64'd1);
        for (int i = 0; i < 15; i++) pop();
        check("drop_tail", log_rd_data, 64'h80000000_0000100F);
        pop();
        check("drop_drained", 64'(log_empty), 64'd1);

        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("clr2_cnt", 64'(taint_cnt), 64'd0);
        check("clr2_alarm", 64'(alarm), 64'd0);
        check("clr2_ovf", 64'(log_ovf), 64'd0);

        // Same again, but the 17th push coincides with a pop: nothing dropped.
        for (int i = 0; i < 16; i++) send(64'h80000000_00002000 + 64'(i), 1'b1);
        log_rd_en = 1'b1;
        send(64'h80000000_00002010, 1'b1);
        log_rd_en = 1'b0;
        check("pp_count", 64'(log_count), 64'd16);
        check("pp_ovf", 64'(log_ovf), 64'd0);
        check("pp_head", log_rd_data, 64'h80000000_00002001);
        check("pp_cnt", 64'(taint_cnt), 64'd17);

        // Asynchronous reset mid-stream with five log entries and alarm raised.
        for (int i = 0; i < 11; i++) pop();
        check("pre_rst_count", 64'(log_count), 64'd5);
        check("pre_rst_alarm", 64'(alarm), 64'd1);
        in_valid = 1'b1;
        in_data  = 64'h55555555_66666666;
        in_alu   = 1'b0;
        idle();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        in_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
